// File: rtl/wb_stage_param_if.sv
// rtl/wb_stage_param_if.sv - MEM/WB slot inputs and register-file write port
interface wb_stage_param_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
);
    logic              in_valid;
    logic              in_reg_write;
    logic [1:0]        in_wb_sel;
    logic [1:0]        in_load_size;
    logic              in_load_signed;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_link;
    logic [DATA_W-1:0] in_imm;
    logic [RA_W-1:0]   in_rd;
    logic              wb_en;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, in_reg_write, in_wb_sel, in_load_size, in_load_signed,
               in_alu_result, in_mem_data, in_link, in_imm, in_rd,
        input  wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_reg_write, in_wb_sel, in_load_size, in_load_signed,
               in_alu_result, in_mem_data, in_link, in_imm, in_rd,
        output wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_stage_param.sv
// rtl/wb_stage_param.sv - MEM/WB pipeline register, load extension, result select, retired counter
module wb_stage_param #(
    parameter int DATA_W   = 16,
    parameter int RA_W     = 3,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               clr_retired,
    output logic [CNT_W-1:0]   retired,
    wb_stage_param_if.slave    bus
);
    localparam int  HALF_W = DATA_W / 2;
    localparam bit  ZR     = (ZERO_REG != 0);

    logic              valid_q;
    logic              rw_q;
    logic [1:0]        sel_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] link_q;
    logic [DATA_W-1:0] imm_q;
    logic [RA_W-1:0]   rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            valid_q  <= 1'b0;
            rw_q     <= 1'b0;
            sel_q    <= 2'b00;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            alu_q    <= '0;
            mem_q    <= '0;
            link_q   <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
        end else if (!stall) begin
            valid_q  <= bus.in_valid;
            rw_q     <= bus.in_reg_write;
            sel_q    <= bus.in_wb_sel;
            size_q   <= bus.in_load_size;
            signed_q <= bus.in_load_signed;
            alu_q    <= bus.in_alu_result;
            mem_q    <= bus.in_mem_data;
            link_q   <= bus.in_link;
            imm_q    <= bus.in_imm;
            rd_q     <= bus.in_rd;
        end
    end

    // clear beats increment; a flushed or stalled slot is not retired this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (clr_retired) begin
            retired <= '0;
        end else if (valid_q && !stall && !flush) begin
            retired <= retired + 1'b1;
        end
    end

    logic [DATA_W-1:0] byte_ext;
    logic [DATA_W-1:0] half_ext;
    logic [DATA_W-1:0] load_val;

    assign byte_ext = {{(DATA_W-8){signed_q & mem_q[7]}}, mem_q[7:0]};
    assign half_ext = {{(DATA_W-HALF_W){signed_q & mem_q[HALF_W-1]}}, mem_q[HALF_W-1:0]};

    always_comb begin
        load_val = mem_q;
        case (size_q)
            2'b00:   load_val = byte_ext;
            2'b01:   load_val = half_ext;
            default: load_val = mem_q;
        endcase
    end

    always_comb begin
        bus.wb_data = alu_q;
        case (sel_q)
            2'b00:   bus.wb_data = alu_q;
            2'b01:   bus.wb_data = load_val;
            2'b10:   bus.wb_data = link_q;
            default: bus.wb_data = imm_q;
        endcase
    end

    assign bus.wb_en   = valid_q & rw_q & ~(ZR & (rd_q == '0));
    assign bus.wb_addr = rd_q;
endmodule

// File: tb/tb_wb_stage_param.sv
// tb/tb_wb_stage_param.sv - directed bench for wb_stage_param (default and ZERO_REG=0/CNT_W=4 instances)
module tb_wb_stage_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic clr_retired = 1'b0;
    logic [15:0] retired_a;
    logic [3:0]  retired_b;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_stage_param_if #(.DATA_W(16), .RA_W(3)) ifa ();
    wb_stage_param_if #(.DATA_W(16), .RA_W(3)) ifb ();

    wb_stage_param #(.DATA_W(16), .RA_W(3), .CNT_W(16), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .clr_retired(clr_retired), .retired(retired_a), .bus(ifa.slave)
    );

    wb_stage_param #(.DATA_W(16), .RA_W(3), .CNT_W(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .clr_retired(clr_retired), .retired(retired_b), .bus(ifb.slave)
    );

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [1:0] size, input logic sgn,
                         input logic [15:0] alu, input logic [15:0] mem,
                         input logic [15:0] link, input logic [15:0] imm,
                         input logic [2:0] rd);
        ifa.in_valid = v;      ifb.in_valid = v;
        ifa.in_reg_write = rw; ifb.in_reg_write = rw;
        ifa.in_wb_sel = sel;   ifb.in_wb_sel = sel;
        ifa.in_load_size = size;  ifb.in_load_size = size;
        ifa.in_load_signed = sgn; ifb.in_load_signed = sgn;
        ifa.in_alu_result = alu;  ifb.in_alu_result = alu;
        ifa.in_mem_data = mem;    ifb.in_mem_data = mem;
        ifa.in_link = link;       ifb.in_link = link;
        ifa.in_imm = imm;         ifb.in_imm = imm;
        ifa.in_rd = rd;           ifb.in_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        drive(0, 0, 2'b00, 2'b00, 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_wb_en", ifa.wb_en, 0);
        chk("rst_wb_data", ifa.wb_data, 0);
        chk("rst_wb_addr", ifa.wb_addr, 0);
        chk("rst_retired", retired_a, 0);
        repeat (5) tick();
        chk("idle_wb_en", ifa.wb_en, 0);
        chk("idle_retired", retired_a, 0);

        drive(1, 1, 2'b01, 2'b00, 1, 16'h0, 16'h00F3, 16'h0, 16'h0, 3'd1);
        tick();
        chk("byte_signed", ifa.wb_data, 16'hFFF3);
        chk("byte_signed_en", ifa.wb_en, 1);
        chk("byte_signed_addr", ifa.wb_addr, 1);
        chk("first_not_yet_retired", retired_a, 0);
        drive(1, 1, 2'b01, 2'b00, 0, 16'h0, 16'h00F3, 16'h0, 16'h0, 3'd1);
        tick();
        chk("byte_unsigned", ifa.wb_data, 16'h00F3);
        chk("retired_after_one", retired_a, 1);
        drive(1, 1, 2'b01, 2'b10, 1, 16'h0, 16'h00F3, 16'h0, 16'h0, 3'd1);
        tick();
        chk("full_load", ifa.wb_data, 16'h00F3);
        drive(1, 1, 2'b01, 2'b01, 1, 16'h0, 16'h00F3, 16'h0, 16'h0, 3'd1);
        tick();
        chk("half_signed_is_byte", ifa.wb_data, 16'hFFF3);
        drive(1, 1, 2'b10, 2'b00, 1, 16'h0, 16'h00F3, 16'h1234, 16'h0, 3'd2);
        #1;
        chk("link_not_comb", ifa.wb_data, 16'hFFF3);
        tick();
        chk("link_sel", ifa.wb_data, 16'h1234);
        drive(1, 1, 2'b11, 2'b00, 1, 16'h0, 16'h80F3, 16'h0, 16'hBEEF, 3'd2);
        tick();
        chk("imm_sel", ifa.wb_data, 16'hBEEF);
        drive(1, 1, 2'b00, 2'b00, 1, 16'h5A5A, 16'h80F3, 16'h0, 16'h0, 3'd3);
        tick();
        chk("alu_sel", ifa.wb_data, 16'h5A5A);
        chk("retired_six", retired_a, 6);

        drive(1, 1, 2'b00, 2'b00, 0, 16'h0077, 16'h0, 16'h0, 16'h0, 3'd0);
        tick();
        chk("zero_reg_suppressed", ifa.wb_en, 0);
        chk("zero_reg_allowed", ifb.wb_en, 1);
        chk("zero_reg_addr", ifb.wb_addr, 0);

        drive(1, 1, 2'b00, 2'b00, 0, 16'h00AA, 16'h0, 16'h0, 16'h0, 3'd5);
        tick();
        chk("zero_reg_counted", retired_a, 8);
        stall = 1'b1;
        drive(1, 1, 2'b00, 2'b00, 0, 16'h1111, 16'h0, 16'h0, 16'h0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_en", ifa.wb_en, 1);
            chk("stall_addr", ifa.wb_addr, 5);
            chk("stall_data", ifa.wb_data, 16'h00AA);
            chk("stall_retired", retired_a, 8);
        end
        stall = 1'b0;
        tick();
        chk("unstall_retired", retired_a, 9);
        chk("unstall_data", ifa.wb_data, 16'h1111);

        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_stall_en", ifa.wb_en, 0);
        chk("flush_stall_data", ifa.wb_data, 0);
        chk("flush_retired", retired_a, 9);
        stall = 1'b0;
        flush = 1'b0;
        drive(0, 0, 2'b00, 2'b00, 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
        tick();
        chk("bubble_not_counted", retired_a, 9);
        chk("bubble_not_counted_b", retired_b, 9);

        clr_retired = 1'b1;
        tick();
        clr_retired = 1'b0;
        chk("clr_idle", retired_b, 0);
        drive(1, 1, 2'b00, 2'b00, 0, 16'h0003, 16'h0, 16'h0, 16'h0, 3'd3);
        repeat (17) tick();
        chk("wrap_at_16_b", retired_b, 0);
        chk("no_wrap_16_a", retired_a, 16);
        drive(0, 0, 2'b00, 2'b00, 0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
        tick();
        chk("wrap_to_1_b", retired_b, 1);
        chk("count_17_a", retired_a, 17);

        drive(1, 1, 2'b00, 2'b00, 0, 16'h0003, 16'h0, 16'h0, 16'h0, 3'd3);
        tick();
        clr_retired = 1'b1;
        tick();
        clr_retired = 1'b0;
        chk("clr_wins_a", retired_a, 0);
        chk("clr_wins_b", retired_b, 0);
        tick();
        chk("count_after_clr", retired_a, 1);
        chk("pre_reset_en", ifa.wb_en, 1);

        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_en", ifa.wb_en, 0);
        chk("async_rst_data", ifa.wb_data, 0);
        chk("async_rst_retired", retired_a, 0);

        stall = 1'b1;
        drive(1, 1, 2'b00, 2'b00, 0, 16'h0042, 16'h0, 16'h0, 16'h0, 3'd6);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_stall_empty", ifa.wb_en, 0);
        stall = 1'b0;
        tick();
        chk("rst_stall_release_en", ifa.wb_en, 1);
        chk("rst_stall_release_addr", ifa.wb_addr, 6);
        chk("rst_stall_release_data", ifa.wb_data, 16'h0042);
        chk("rst_stall_retired", retired_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_stage_param.md
# wb_stage_param

Parametrised write-back stage: a MEM/WB pipeline register with stall and flush, followed by a four-way result select. Loaded data can be byte- or half-width, sign- or zero-extended. Writes to register 0 can be suppressed, and a retired-instruction counter is maintained. The block sits between the memory stage and the register-file write port. Its outputs also drive the bypass network.

## Interface
Parameters:
- DATA_W, 16, datapath width; even, ≥16
- RA_W, 3, register address width
- CNT_W, 16, retired-counter width
- ZERO_REG, 1, when 1 no write is issued to register 0

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold pipeline register contents
- flush  in  1  load a bubble into the pipeline register
- in_valid  in  1  incoming slot holds a real instruction
- in_reg_write  in  1  instruction writes a register
- in_wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 IMM
- in_load_size  in  2  00 byte (8b), 01 half (DATA_W/2), 1x full
- in_load_signed  in  1  1 = sign-extend narrow loads, 0 = zero-extend
- in_alu_result  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  raw memory read data; narrow data in the low bits
- in_link  in  DATA_W  return address
- in_imm  in  DATA_W  immediate for load-immediate
- in_rd  in  RA_W  destination register
- clr_retired  in  1  synchronous clear of retired counter
- wb_en  out  1  register-file write enable; also the bypass-valid signal
- wb_addr  out  RA_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- retired  out  CNT_W  count of retired instructions

## Operation
- Pipeline register fields: valid_q, rw_q, sel_q, size_q, signed_q, alu_q, mem_q, link_q, imm_q, rd_q.
- Update priority on each edge:
  - flush: valid_q←0; all other fields←0.
  - else stall: all fields hold.
  - else: all fields←in_*.
- flush has priority over stall.
- wb_en = valid_q & rw_q & ~(ZERO_REG & (rd_q==0)).
- wb_en does not depend on stall. A held entry keeps rewriting the same value to the same register; this is harmless.
- wb_addr = rd_q.
- wb_data select (combinational from register state):
  - sel 00: alu_q
  - sel 01: mem_q extended per size_q and signed_q
  - sel 10: link_q
  - sel 11: imm_q
- Load extension for sel 01:
  - byte: mem_q[7:0], upper DATA_W-8 bits = signed_q ? mem_q[7] : 0.
  - half: mem_q[DATA_W/2-1:0], extended the same way from bit DATA_W/2-1. When DATA_W=16, half is identical to byte.
  - full: mem_q unchanged; signed_q ignored.
- size_q and signed_q are ignored for sel other than 01.
- Retired counter, on each edge:
  - clr_retired: retired←0. This wins over an increment in the same cycle.
  - else if valid_q & ~stall & ~flush: retired←retired+1, modulo 2^CNT_W. It wraps from all-ones to 0 with no flag.
  - A flushed entry is not counted, whether it is the entry being flushed out or the one being replaced.
  - Instructions with in_reg_write=0 (e.g. stores, branches) still count if valid.
- No state machine beyond the pipeline register and counter. The block has no backpressure output; stall comes from the hazard unit.

## Timing
- Reset (asynchronous, immediate):
  - all pipeline fields and retired = 0
  - hence wb_en=0, wb_addr=0, wb_data=0 (sel ALU, alu_q=0)
- Latency: in_* sampled on edge N appear on wb_* after edge N. This is one cycle, with a combinational path from register to output only.
- No combinational path from any in_* port to wb_*.
- stall held k cycles: wb_* are constant for those k cycles. The entry is counted exactly once, on the first edge with stall=0.
- flush and stall in the same cycle: a bubble is loaded; wb_en=0 on the next cycle.
- Reset deasserted mid-stall: the register stays empty until the first non-stall edge.
- Reset asserted mid-operation: outputs drop to reset values without waiting for a clock edge. The counter is lost.

## Test plan
- Reset then idle: reset=1 for 2 cycles, release -> wb_en=0, wb_data=0, retired=0; no change over 5 idle cycles.
- Source/extension sweep (DATA_W=16):
  - mem=0x00F3, sel=01, byte, signed -> wb_data=0xFFF3.
  - Same load unsigned -> 0x00F3.
  - full load -> 0x00F3.
  - sel=10 with link=0x1234 -> wb_data=0x1234, one cycle after capture.
- Zero register: in_rd=0, reg_write=1, valid=1:
  - ZERO_REG=1 -> wb_en=0, retired increments.
  - ZERO_REG=0 -> wb_en=1.
- Stall/flush:
  - Capture rd=5, alu=0x00AA, then stall 3 cycles -> wb_en=1, wb_addr=5, wb_data=0x00AA held for 4 cycles; retired +1 only after stall drops.
  - Flush with stall=1 -> wb_en=0 next cycle; retired unchanged.
- Counter:
  - CNT_W=4, 17 back-to-back valid instructions -> retired wraps to 1.
  - clr_retired with a valid retiring entry in the same cycle -> retired=0.
- Async reset mid-stream: assert reset between clock edges while wb_en=1 -> wb_en=0 and retired=0 before the next rising edge.
